// File: rtl/assoc_wb_cache_if.sv
// assoc_wb_cache_if: request/response and upper-memory signals of assoc_wb_cache.
//   slave  modport : the cache's view (request and memory responses in, data and memory requests out)
//   master modport : the pipeline/memory side's view
//   Pipeline side  : addr_i, read_en_i, read_valid_o, read_word_o, write_en_i, write_be_i,
//                    write_word_i, write_valid_o
//   Memory side    : mem_addr_o, mem_read_en_o, mem_read_valid_i, mem_read_data_i,
//                    mem_write_en_o, mem_write_data_o, mem_write_valid_i
interface assoc_wb_cache_if #(
  parameter int unsigned LineSize = 256
);
  logic [31:0]         addr_i;
  logic                read_en_i;
  logic                read_valid_o;
  logic [31:0]         read_word_o;
  logic                write_en_i;
  logic [3:0]          write_be_i;
  logic [31:0]         write_word_i;
  logic                write_valid_o;
  logic [31:0]         mem_addr_o;
  logic                mem_read_en_o;
  logic                mem_read_valid_i;
  logic [LineSize-1:0] mem_read_data_i;
  logic                mem_write_en_o;
  logic [LineSize-1:0] mem_write_data_o;
  logic                mem_write_valid_i;

  modport slave (
    input  addr_i, read_en_i, write_en_i, write_be_i, write_word_i,
    input  mem_read_valid_i, mem_read_data_i, mem_write_valid_i,
    output read_valid_o, read_word_o, write_valid_o,
    output mem_addr_o, mem_read_en_o, mem_write_en_o, mem_write_data_o
  );

  modport master (
    output addr_i, read_en_i, write_en_i, write_be_i, write_word_i,
    output mem_read_valid_i, mem_read_data_i, mem_write_valid_i,
    input  read_valid_o, read_word_o, write_valid_o,
    input  mem_addr_o, mem_read_en_o, mem_write_en_o, mem_write_data_o
  );
endinterface

// File: rtl/assoc_wb_cache.sv
// assoc_wb_cache: N-way set-associative write-back / write-allocate cache with
// round-robin replacement between a load/store stage and a line-wide memory.
//   clk_i : clock, rising edge
//   rst_i : asynchronous reset, active-high
//   bus   : assoc_wb_cache_if.slave (pipeline request/response + memory refill/write-back)
// Hits complete in the request cycle; misses write back a dirty victim, then refill.
// Optional macro CACHE_BYPASS_EN: complete the pending request in the refill-data cycle.
module assoc_wb_cache #(
  parameter int unsigned ByteOffsetBits = 5,
  parameter int unsigned IndexBits      = 4,
  parameter int unsigned NrWays         = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  assoc_wb_cache_if.slave   bus
);
  localparam int unsigned TagBits  = 32 - IndexBits - ByteOffsetBits;
  localparam int unsigned LineSize = 8 * (2 ** ByteOffsetBits);
  localparam int unsigned NumSets  = 2 ** IndexBits;
  localparam int unsigned WordBits = ByteOffsetBits - 2;
  localparam int unsigned WayBits  = (NrWays > 1) ? $clog2(NrWays) : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;

  // Storage: tags/data are not reset; valid/dirty/round-robin are.
  logic [TagBits-1:0]  tag_q  [NrWays][NumSets];
  logic [LineSize-1:0] data_q [NrWays][NumSets];
  logic [NumSets-1:0][NrWays-1:0]  valid_q;
  logic [NumSets-1:0][NrWays-1:0]  dirty_q;
  logic [NumSets-1:0][WayBits-1:0] rr_q;

  logic [1:0]           state_q, state_d;
  logic [WayBits-1:0]   vic_way_q;
  logic [IndexBits-1:0] miss_index_q;
  logic [TagBits-1:0]   miss_tag_q;

  // Address split of the current request
  logic [WordBits-1:0]  req_word;
  logic [IndexBits-1:0] req_index;
  logic [TagBits-1:0]   req_tag;
  logic                 unused_addr;

  assign req_word    = bus.addr_i[ByteOffsetBits-1:2];
  assign req_index   = bus.addr_i[IndexBits+ByteOffsetBits-1:ByteOffsetBits];
  assign req_tag     = bus.addr_i[31 -: TagBits];
  assign unused_addr = ^bus.addr_i[1:0];

  // Replace one 32-bit word of a line under byte enables
  function automatic logic [LineSize-1:0] merge_word(
    input logic [LineSize-1:0] line,
    input logic [WordBits-1:0] word,
    input logic [3:0]          be,
    input logic [31:0]         data
  );
    logic [LineSize-1:0] res;
    logic [31:0]         mask;
    logic [31:0]         old_w;
    mask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    res   = line;
    old_w = line[{word, 5'b0} +: 32];
    res[{word, 5'b0} +: 32] = (old_w & ~mask) | (data & mask);
    return res;
  endfunction

  // Tag lookup and victim choice (lowest invalid way, else round-robin pointer)
  logic               hit_c;
  logic [WayBits-1:0] hit_way_c;
  logic               inv_found_c;
  logic [WayBits-1:0] inv_way_c;
  logic [WayBits-1:0] victim_way_c;
  logic [LineSize-1:0] hit_line_c;

  always_comb begin
    hit_c       = 1'b0;
    hit_way_c   = '0;
    inv_found_c = 1'b0;
    inv_way_c   = '0;
    for (int w = 0; w < NrWays; w++) begin
      if (!hit_c && valid_q[req_index][w] && (tag_q[w][req_index] == req_tag)) begin
        hit_c     = 1'b1;
        hit_way_c = WayBits'(w);
      end
      if (!inv_found_c && !valid_q[req_index][w]) begin
        inv_found_c = 1'b1;
        inv_way_c   = WayBits'(w);
      end
    end
    victim_way_c = inv_found_c ? inv_way_c : rr_q[req_index];
    hit_line_c   = data_q[hit_way_c][req_index];
  end

  // Line installed on refill, with an optional write merged in during bypass
  logic [LineSize-1:0] fill_line_c;
  logic                fill_dirty_c;

  always_comb begin
`ifdef CACHE_BYPASS_EN
    fill_line_c  = bus.write_en_i ?
                   merge_word(bus.mem_read_data_i, req_word, bus.write_be_i, bus.write_word_i) :
                   bus.mem_read_data_i;
    fill_dirty_c = bus.write_en_i;
`else
    fill_line_c  = bus.mem_read_data_i;
    fill_dirty_c = 1'b0;
`endif
  end

  // Next-state and outputs
  logic        miss_c, wr_hit_c, wb_done_c, fill_c;
  logic        read_valid_c, write_valid_c, mem_read_en_c, mem_write_en_c;
  logic [31:0] read_word_c, mem_addr_c;
  logic [LineSize-1:0] mem_write_data_c;

  always_comb begin
    state_d          = state_q;
    miss_c           = 1'b0;
    wr_hit_c         = 1'b0;
    wb_done_c        = 1'b0;
    fill_c           = 1'b0;
    read_valid_c     = 1'b0;
    write_valid_c    = 1'b0;
    mem_read_en_c    = 1'b0;
    mem_write_en_c   = 1'b0;
    read_word_c      = '0;
    mem_addr_c       = '0;
    mem_write_data_c = '0;
    case (state_q)
      IDLE: begin
        if (bus.write_en_i || bus.read_en_i) begin
          if (hit_c) begin
            // Write has priority when both are requested
            if (bus.write_en_i) begin
              wr_hit_c      = 1'b1;
              write_valid_c = 1'b1;
            end else begin
              read_valid_c = 1'b1;
              read_word_c  = hit_line_c[{req_word, 5'b0} +: 32];
            end
          end else begin
            miss_c  = 1'b1;
            state_d = (valid_q[req_index][victim_way_c] && dirty_q[req_index][victim_way_c]) ?
                      WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        mem_write_en_c   = 1'b1;
        mem_addr_c       = {tag_q[vic_way_q][miss_index_q], miss_index_q, {ByteOffsetBits{1'b0}}};
        mem_write_data_c = data_q[vic_way_q][miss_index_q];
        if (bus.mem_write_valid_i) begin
          wb_done_c = 1'b1;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        mem_read_en_c = 1'b1;
        mem_addr_c    = {miss_tag_q, miss_index_q, {ByteOffsetBits{1'b0}}};
        if (bus.mem_read_valid_i) begin
          fill_c  = 1'b1;
          state_d = IDLE;
`ifdef CACHE_BYPASS_EN
          if (bus.write_en_i) begin
            write_valid_c = 1'b1;
          end else if (bus.read_en_i) begin
            read_valid_c = 1'b1;
            read_word_c  = bus.mem_read_data_i[{req_word, 5'b0} +: 32];
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.read_valid_o     = read_valid_c;
  assign bus.read_word_o      = read_word_c;
  assign bus.write_valid_o    = write_valid_c;
  assign bus.mem_read_en_o    = mem_read_en_c;
  assign bus.mem_write_en_o   = mem_write_en_c;
  assign bus.mem_addr_o       = mem_addr_c;
  assign bus.mem_write_data_o = mem_write_data_c;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Miss context, valid/dirty bits and round-robin pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vic_way_q    <= '0;
      miss_index_q <= '0;
      miss_tag_q   <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      rr_q         <= '0;
    end else begin
      if (miss_c) begin
        vic_way_q    <= victim_way_c;
        miss_index_q <= req_index;
        miss_tag_q   <= req_tag;
      end
      if (wr_hit_c)  dirty_q[req_index][hit_way_c] <= 1'b1;
      if (wb_done_c) dirty_q[miss_index_q][vic_way_q] <= 1'b0;
      if (fill_c) begin
        valid_q[miss_index_q][vic_way_q] <= 1'b1;
        dirty_q[miss_index_q][vic_way_q] <= fill_dirty_c;
        // Pointer only moves when a live line was displaced
        if (valid_q[miss_index_q][vic_way_q]) begin
          rr_q[miss_index_q] <= (rr_q[miss_index_q] == WayBits'(NrWays - 1)) ?
                                '0 : rr_q[miss_index_q] + WayBits'(1);
        end
      end
    end
  end

  // Tag and data arrays
  always_ff @(posedge clk_i) begin
    if (wr_hit_c) begin
      data_q[hit_way_c][req_index] <= merge_word(hit_line_c, req_word, bus.write_be_i, bus.write_word_i);
    end
    if (fill_c) begin
      tag_q[vic_way_q][miss_index_q]  <= miss_tag_q;
      data_q[vic_way_q][miss_index_q] <= fill_line_c;
    end
  end
endmodule

// File: tb/tb_assoc_wb_cache.sv
// tb_assoc_wb_cache: directed bench for assoc_wb_cache (ByteOffsetBits=5, IndexBits=4, NrWays=2).
module tb_assoc_wb_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  assoc_wb_cache_if #(.LineSize(256)) bus ();

  assoc_wb_cache #(
    .ByteOffsetBits(5),
    .IndexBits(4),
    .NrWays(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base, input logic [31:0] w1);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
    l[63:32] = w1;
    return l;
  endfunction

  logic [255:0] line0, line1, line2, line3;
  logic [255:0] wb_line;

  initial begin
    line0 = make_line(32'h1000_0000, 32'hDEAD_BEEF);
    line1 = make_line(32'h2000_0000, 32'h1111_1111);
    line2 = make_line(32'h3000_0000, 32'h2222_2222);
    line3 = make_line(32'h4000_0000, 32'h3333_3333);
    bus.addr_i = '0; bus.read_en_i = 0; bus.write_en_i = 0;
    bus.write_be_i = '0; bus.write_word_i = '0;
    bus.mem_read_valid_i = 0; bus.mem_read_data_i = '0; bus.mem_write_valid_i = 0;

    // Reset values
    #12;
    chk("rst_read_valid",  32'(bus.read_valid_o), 32'd0);
    chk("rst_write_valid", 32'(bus.write_valid_o), 32'd0);
    chk("rst_mem_rd_en",   32'(bus.mem_read_en_o), 32'd0);
    chk("rst_mem_wr_en",   32'(bus.mem_write_en_o), 32'd0);
    chk("rst_mem_addr",    bus.mem_addr_o, 32'h0);
    chk("rst_read_word",   bus.read_word_o, 32'h0);
    rst = 0;

    // Cold read miss of 0x104
    tick();
    bus.addr_i = 32'h104; bus.read_en_i = 1;
    #1 chk("miss_no_valid", 32'(bus.read_valid_o), 32'd0);
    tick();
    chk("refill_en",   32'(bus.mem_read_en_o), 32'd1);
    chk("refill_addr", bus.mem_addr_o, 32'h100);
    chk("refill_no_wb", 32'(bus.mem_write_en_o), 32'd0);
    bus.mem_read_valid_i = 1; bus.mem_read_data_i = line0;
    #1;
`ifdef CACHE_BYPASS_EN
    chk("bypass_valid", 32'(bus.read_valid_o), 32'd1);
    chk("bypass_word",  bus.read_word_o, 32'hDEAD_BEEF);
`else
    chk("fill_cycle_no_valid", 32'(bus.read_valid_o), 32'd0);
`endif
    tick();
    bus.mem_read_valid_i = 0;
    #1;
    chk("hit_after_fill",  32'(bus.read_valid_o), 32'd1);
    chk("hit_word",        bus.read_word_o, 32'hDEAD_BEEF);
    chk("hit_no_mem_rd",   32'(bus.mem_read_en_o), 32'd0);

    // Repeat read, then a partial write hit
    tick();
    bus.read_en_i = 0;
    tick();
    bus.read_en_i = 1;
    #1 chk("repeat_hit", 32'(bus.read_valid_o), 32'd1);
    tick();
    bus.read_en_i = 0; bus.write_en_i = 1; bus.write_be_i = 4'b0011; bus.write_word_i = 32'h0000_CAFE;
    #1 chk("write_hit_valid", 32'(bus.write_valid_o), 32'd1);
    tick();
    bus.write_en_i = 0; bus.read_en_i = 1;
    #1 chk("merged_word", bus.read_word_o, 32'hDEAD_CAFE);

    // Fill way1 of set 8 with 0x1104 (clean)
    tick();
    bus.addr_i = 32'h1104;
    tick();
    chk("fill2_addr", bus.mem_addr_o, 32'h1100);
    bus.mem_read_valid_i = 1; bus.mem_read_data_i = line1;
    tick();
    bus.mem_read_valid_i = 0;
    #1 chk("fill2_word", bus.read_word_o, 32'h1111_1111);

    // 0x2104 evicts dirty way0: write-back then refill
    tick();
    bus.addr_i = 32'h2104;
    tick();
    wb_line = bus.mem_write_data_o;
    chk("wb_en",     32'(bus.mem_write_en_o), 32'd1);
    chk("wb_rd_off", 32'(bus.mem_read_en_o), 32'd0);
    chk("wb_addr",   bus.mem_addr_o, 32'h100);
    chk("wb_word1",  wb_line[63:32], 32'hDEAD_CAFE);
    chk("wb_word0",  wb_line[31:0], 32'h1000_0000);
    bus.mem_write_valid_i = 1;
    tick();
    bus.mem_write_valid_i = 0;
    #1;
    chk("wb_done_en",   32'(bus.mem_write_en_o), 32'd0);
    chk("after_wb_rd",  32'(bus.mem_read_en_o), 32'd1);
    chk("after_wb_addr", bus.mem_addr_o, 32'h2100);
    bus.mem_read_valid_i = 1; bus.mem_read_data_i = line2;
    tick();
    bus.mem_read_valid_i = 0;
    #1 chk("fill3_word", bus.read_word_o, 32'h2222_2222);

    // Read and write together on a hit: write wins
    tick();
    bus.write_en_i = 1; bus.write_be_i = 4'b1111; bus.write_word_i = 32'h1234_5678;
    #1;
    chk("rw_write_valid", 32'(bus.write_valid_o), 32'd1);
    chk("rw_read_held",   32'(bus.read_valid_o), 32'd0);
    tick();
    bus.write_en_i = 0;
    #1;
    chk("rw_read_valid", 32'(bus.read_valid_o), 32'd1);
    chk("rw_read_word",  bus.read_word_o, 32'h1234_5678);

    // Reset during refill of 0x104 (victim is clean way1 via round-robin)
    tick();
    bus.addr_i = 32'h104;
    tick();
    chk("pre_rst_rd_en", 32'(bus.mem_read_en_o), 32'd1);
    chk("pre_rst_addr",  bus.mem_addr_o, 32'h100);
    rst = 1;
    #1;
    chk("rst_drops_rd_en", 32'(bus.mem_read_en_o), 32'd0);
    chk("rst_drops_addr",  bus.mem_addr_o, 32'h0);
    tick();
    rst = 0;
    #1 chk("post_rst_miss", 32'(bus.read_valid_o), 32'd0);
    tick();
    chk("post_rst_rd_en", 32'(bus.mem_read_en_o), 32'd1);
    chk("post_rst_addr",  bus.mem_addr_o, 32'h100);
    bus.mem_read_valid_i = 1; bus.mem_read_data_i = line0;
    tick();
    bus.mem_read_valid_i = 0;
    #1 chk("post_rst_word", bus.read_word_o, 32'hDEAD_BEEF);

    // Read miss of 0x204 (set 0)
    tick();
    bus.addr_i = 32'h204;
    tick();
    chk("m204_addr", bus.mem_addr_o, 32'h200);
    bus.mem_read_valid_i = 1; bus.mem_read_data_i = line3;
    #1;
`ifdef CACHE_BYPASS_EN
    chk("m204_bypass_valid", 32'(bus.read_valid_o), 32'd1);
    chk("m204_bypass_word",  bus.read_word_o, 32'h3333_3333);
`else
    chk("m204_fill_no_valid", 32'(bus.read_valid_o), 32'd0);
`endif
    tick();
    bus.mem_read_valid_i = 0;
    #1 chk("m204_hit_word", bus.read_word_o, 32'h3333_3333);
    tick();
    bus.read_en_i = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/assoc_wb_cache.md
Name: assoc_wb_cache

Overview:
Parametrised N-way set-associative cache with read and write ports, write-back/write-allocate policy and round-robin replacement. It sits between the pipeline load/store stage (or instruction fetch) and a line-wide upper memory. It generalises the direct-mapped read-only cache with associativity, dirty tracking, victim write-back and per-byte write enables.

Parameters:
ByteOffsetBits, 5, log2 bytes per line (line = 2**ByteOffsetBits bytes, min 3)
IndexBits, 4, log2 number of sets
NrWays, 2, ways per set, power of 2, 1..8
TagBits, 32-IndexBits-ByteOffsetBits (localparam), tag width
LineSize, 8*2**ByteOffsetBits (localparam), line width in bits

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous reset, active-high
addr_i  in  32  byte address of request, held stable until read_valid_o/write_valid_o
read_en_i  in  1  read request, level, held until read_valid_o
read_valid_o  out  1  read data valid this cycle
read_word_o  out  32  read data word
write_en_i  in  1  write request, level, held until write_valid_o
write_be_i  in  4  byte enables for write_word_i
write_word_i  in  32  write data
write_valid_o  out  1  write accepted; line updated at this clock edge
mem_addr_o  out  32  line-aligned memory address (offset bits zero)
mem_read_en_o  out  1  line refill request, held until mem_read_valid_i
mem_read_valid_i  in  1  mem_read_data_i valid, one-cycle pulse
mem_read_data_i  in  LineSize  refill line
mem_write_en_o  out  1  victim write-back request, held until mem_write_valid_i
mem_write_data_o  out  LineSize  victim line
mem_write_valid_i  in  1  write-back accepted, one-cycle pulse

Behaviour:
- Reset (async, immediate): all valid/dirty bits 0, round-robin pointers 0, FSM=IDLE; read_valid_o, write_valid_o, mem_read_en_o, mem_write_en_o = 0; read_word_o, mem_addr_o, mem_write_data_o = 0. Tags/data need not reset.
- Address split: word = addr_i[ByteOffsetBits-1:2], index = addr_i[IndexBits+ByteOffsetBits-1:ByteOffsetBits], tag = upper TagBits. addr_i[1:0] ignored.
- Both read_en_i and write_en_i set: write wins; read waits.
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE hit (valid && tag match in any way): read hit gives read_valid_o=1 combinationally the same cycle with the selected word. Write hit gives write_valid_o=1 the same cycle; enabled bytes merged at the edge; dirty=1. Zero-wait-state.
- IDLE miss: victim = lowest-index invalid way; otherwise way[rr_ptr[index]]. Victim latched. If victim valid && dirty, go to WRITEBACK, else REFILL.
- WRITEBACK: mem_write_en_o=1, mem_addr_o={victim tag,index,0}, mem_write_data_o=victim line. On mem_write_valid_i, clear victim dirty and go to REFILL.
- REFILL: mem_read_en_o=1, mem_addr_o={req tag,index,0}. On mem_read_valid_i, install line in victim way (valid=1, dirty=0, tag), advance rr_ptr[index] modulo NrWays only when the replaced way was valid, go to IDLE. The request then hits in the following cycle.
- Request dropped during WRITEBACK/REFILL: the memory transaction completes and the line is installed; no valid output is produced.
- Memory enables never both high. Outputs are valid only while the request is held.
- rst_i mid-miss: transaction abandoned, enables drop asynchronously. Memory must tolerate this.

Optional Feature:
CACHE_BYPASS_EN
- Defined: in the mem_read_valid_i cycle, the pending read returns read_valid_o=1 with the word taken directly from mem_read_data_i. A pending write is merged into the installed line (dirty=1) with write_valid_o=1. Miss latency drops by 1 cycle.
- Undefined: no valid output during refill; the request completes on the IDLE hit cycle after.

Test Plan (ByteOffsetBits=5, IndexBits=4, NrWays=2):
- Reset, read 0x104 -> mem_read_en_o=1, mem_addr_o=0x100. Return a line with word1=0xDEADBEEF -> next cycle read_valid_o=1, read_word_o=0xDEADBEEF. A repeat read gives same-cycle hit with mem_read_en_o=0.
- Write 0x104, be=4'b0011, data=0x0000CAFE, after the fill above -> write_valid_o same cycle. Next read 0x104 returns 0xDEADCAFE.
- After the prior two steps, read 0x1104 (fills way1), then read 0x2104 -> victim way0 dirty. mem_write_en_o=1, mem_addr_o=0x100, data word1=0xDEADCAFE. After mem_write_valid_i, mem_read_en_o=1, mem_addr_o=0x2100.
- Read and write both asserted for 0x104 on a hit -> write_valid_o=1, read_valid_o=0. Next cycle read returns the new data.
- Assert rst_i during REFILL for 0x104 -> mem_read_en_o=0 immediately. After release, read 0x104 misses again.
- CACHE_BYPASS_EN defined: read miss 0x204 -> read_valid_o=1 in the mem_read_valid_i cycle with word1 of mem_read_data_i.
